mem_issue_queue: RTL and testbench
==================================

Name: mem_issue_queue

Overview:
- In-order issue buffer directly upstream of the execution top's memory port.
- Accepts dispatched load/store micro-ops with operands already read, holds them in program order, and presents the oldest to the memblock via mem_instr_valid/mem_instr_ready.
- Honours backend flush by robid: squashes every buffered entry younger than the flushing instruction.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), width of head/tail pointers.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
flush_valid  in  1  backend flush request
flush_robid  in  `INSTR_ID_WIDTH  robid of the flushing instruction; MSB is the wrap bit, remaining bits are the index
enq_valid  in  1  dispatch offers a micro-op
enq_ready  out  1  queue can accept a micro-op this cycle
enq_instr  in  `INSTR_RANGE  instruction word
enq_pc  in  `PC_RANGE  pc
enq_robid  in  `INSTR_ID_WIDTH  rob id
enq_src1  in  `SRC_RANGE  base operand
enq_src2  in  `SRC_RANGE  store data
enq_prd  in  `PREG_RANGE  destination preg
enq_imm  in  `SRC_RANGE  offset
enq_is_load  in  1  load
enq_is_store  in  1  store
enq_is_unsigned  in  1  zero-extend load
enq_ls_size  in  `LS_SIZE_RANGE  access size
mem_instr_valid  out  1  head entry valid toward memblock
mem_instr_ready  in  1  memblock accepts head
mem_instr, mem_pc, mem_robid, mem_src1, mem_src2, mem_prd, mem_imm, mem_is_load, mem_is_store, mem_is_unsigned, mem_ls_size  out  same widths as enq_*  head entry payload
occupancy  out  PTR_W+1  current entry count

Behaviour:
- Storage: circular array of DEPTH entries; head, tail pointers PTR_W bits; count PTR_W+1 bits. All state updates on rising clock.
- Reset (reset_n=0 at edge): head=tail=count=0. Outputs then: mem_instr_valid=0, enq_ready=1, occupancy=0. Payload outputs are don't-care but X-free; clear storage to 0. Reset mid-operation discards all entries.
- enq_ready = (count != DEPTH).
  - Derived from registered count only; no same-cycle pop bypass. A full queue refuses enq even when a pop occurs.
- Enqueue fires on enq_valid && enq_ready && !flush_valid. Writes the entry at tail; tail+1 (wraps mod DEPTH). An enq offered during a flush cycle is dropped, never stored.
- mem_instr_valid = (count != 0) && !flush_valid. Payload is driven from the head entry (register outputs, no input-to-output path except through flush_valid).
- Dequeue fires on mem_instr_valid && mem_instr_ready; head+1 (wraps).
- Simultaneous enq and deq, no flush: count unchanged, both pointers advance.
- Age compare: an entry is younger than flush_robid iff
  - the wrap bits are equal and entry index > flush index, or
  - the wrap bits differ and entry index < flush index.
  - An equal robid is NOT killed.
- Flush cycle:
  - No enq, no deq.
  - Each live entry is evaluated with the age compare.
  - Because entries are in program order, killed entries form a contiguous tail segment.
  - New count = number of surviving entries counted from head; tail = head + new count (mod DEPTH); head unchanged.
  - Flush with count=0: no effect.
- occupancy = count (registered).
- No assertion on enq_is_load && enq_is_store; the payload is passed through verbatim.

Test Plan:
- Reset, then enq 3 ops (robid 0x01,0x02,0x03) with mem_instr_ready=0 -> occupancy=3, mem_instr_valid=1, mem_robid=0x01; raise ready for 3 cycles -> robids 0x01,0x02,0x03 out in order, occupancy=0, valid=0.
- Fill DEPTH=8 entries, keep enq_valid=1 with ready=1 -> enq_ready=0 on the full cycle even while popping; next cycle enq_ready=1, occupancy=7 then refills to 8.
- Buffer robids 0x05..0x09, flush_robid=0x06 -> next cycle occupancy=2 (0x05,0x06 survive); mem_instr_valid=0 during the flush cycle; subsequent enq of 0x07 lands directly after 0x06.
- Wrap-around age: INSTR_ID_WIDTH=7, buffer robids 0x3E,0x3F,0x40,0x41 (wrap bit toggles), flush_robid=0x3F -> 0x40,0x41 killed, occupancy=2.
- Flush with enq_valid=1 and mem_instr_ready=1 in the same cycle -> no entry written, no pop; head robid unchanged.
- Assert reset_n=0 with 4 entries mid-stream -> next cycle occupancy=0, mem_instr_valid=0, enq_ready=1.

Source files
------------

// File: rtl/mem_issue_queue_if.sv
// Load/store micro-op handshake bundle: valid/ready plus the full operand payload.
// Used both for dispatch into the issue queue and for the queue's output to the memblock.
interface mem_issue_queue_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int ID_W    = 7,
  parameter int SRC_W   = 64,
  parameter int PREG_W  = 6,
  parameter int LS_W    = 2
);
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic [ID_W-1:0]    robid;
  logic [SRC_W-1:0]   src1;
  logic [SRC_W-1:0]   src2;
  logic [PREG_W-1:0]  prd;
  logic [SRC_W-1:0]   imm;
  logic               is_load;
  logic               is_store;
  logic               is_unsigned;
  logic [LS_W-1:0]    ls_size;

  modport master (
    output valid, instr, pc, robid, src1, src2, prd, imm,
           is_load, is_store, is_unsigned, ls_size,
    input  ready
  );

  modport slave (
    input  valid, instr, pc, robid, src1, src2, prd, imm,
           is_load, is_store, is_unsigned, ls_size,
    output ready
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue buffer feeding the memblock; a flush squashes every
// buffered entry younger than the flushing robid.
module mem_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int ID_W    = 7,
  parameter int SRC_W   = 64,
  parameter int PREG_W  = 6,
  parameter int LS_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush_valid,
  input  logic [ID_W-1:0]      flush_robid,
  mem_issue_queue_if.slave     enq,
  mem_issue_queue_if.master    mem,
  output logic [PTR_W:0]       occupancy
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [ID_W-1:0]    robid;
    logic [SRC_W-1:0]   src1;
    logic [SRC_W-1:0]   src2;
    logic [PREG_W-1:0]  prd;
    logic [SRC_W-1:0]   imm;
    logic               is_load;
    logic               is_store;
    logic               is_unsigned;
    logic [LS_W-1:0]    ls_size;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_not_full;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [PTR_W:0]   w_keep_cnt;
  entry_t           w_enq_entry;

  // Robid MSB is the wrap bit; differing wrap bits invert the index ordering.
  function automatic logic is_younger(input logic [ID_W-1:0] entry_id,
                                      input logic [ID_W-1:0] flush_id);
    logic younger;
    if (entry_id[ID_W-1] == flush_id[ID_W-1]) begin
      younger = (entry_id[ID_W-2:0] > flush_id[ID_W-2:0]);
    end else begin
      younger = (entry_id[ID_W-2:0] < flush_id[ID_W-2:0]);
    end
    return younger;
  endfunction

  assign w_not_full = (r_count != FULL_CNT);
  assign w_enq_fire = enq.valid && w_not_full && !flush_valid;
  assign w_deq_fire = mem.valid && mem.ready;

  assign enq.ready  = w_not_full;
  assign occupancy  = r_count;

  assign mem.valid       = (r_count != {(PTR_W+1){1'b0}}) && !flush_valid;
  assign mem.instr       = r_mem[r_head].instr;
  assign mem.pc          = r_mem[r_head].pc;
  assign mem.robid       = r_mem[r_head].robid;
  assign mem.src1        = r_mem[r_head].src1;
  assign mem.src2        = r_mem[r_head].src2;
  assign mem.prd         = r_mem[r_head].prd;
  assign mem.imm         = r_mem[r_head].imm;
  assign mem.is_load     = r_mem[r_head].is_load;
  assign mem.is_store    = r_mem[r_head].is_store;
  assign mem.is_unsigned = r_mem[r_head].is_unsigned;
  assign mem.ls_size     = r_mem[r_head].ls_size;

  // Pack the dispatched micro-op into a storage entry.
  always_comb begin
    w_enq_entry             = '0;
    w_enq_entry.instr       = enq.instr;
    w_enq_entry.pc          = enq.pc;
    w_enq_entry.robid       = enq.robid;
    w_enq_entry.src1        = enq.src1;
    w_enq_entry.src2        = enq.src2;
    w_enq_entry.prd         = enq.prd;
    w_enq_entry.imm         = enq.imm;
    w_enq_entry.is_load     = enq.is_load;
    w_enq_entry.is_store    = enq.is_store;
    w_enq_entry.is_unsigned = enq.is_unsigned;
    w_enq_entry.ls_size     = enq.ls_size;
  end

  // Survivors after a flush: live entries walked from head up to the first killed one.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] slot;
    w_keep_cnt = r_count;
    found      = 1'b0;
    slot       = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = r_head + PTR_W'(i);
      if (!found && ((PTR_W+1)'(i) < r_count) &&
          is_younger(r_mem[slot].robid, flush_robid)) begin
        w_keep_cnt = (PTR_W+1)'(i);
        found      = 1'b1;
      end else begin
        found      = found;
      end
    end
  end

  // Queue state: reset, flush truncation, or normal enqueue/dequeue.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_valid) begin
      r_count <= w_keep_cnt;
      r_tail  <= r_head + w_keep_cnt[PTR_W-1:0];
    end else begin
      if (w_enq_fire) begin
        r_mem[r_tail] <= w_enq_entry;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: a negedge monitor records accepted enqueues
// into a scoreboard and checks every dequeued head against it in order.
module tb_mem_issue_queue;

  logic       clk;
  logic       reset_n;
  logic       flush_valid;
  logic [6:0] flush_robid;
  logic [3:0] occupancy;

  int n_tests;
  int n_fail;
  logic [6:0] sb[$];

  mem_issue_queue_if enq_if ();
  mem_issue_queue_if mem_if ();

  mem_issue_queue dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .flush_valid (flush_valid),
    .flush_robid (flush_robid),
    .enq         (enq_if),
    .mem         (mem_if),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [6:0] r);
    return 32'hC0DE_0000 | {25'd0, r};
  endfunction

  function automatic logic [63:0] mk_src1(input logic [6:0] r);
    return 64'h0000_1000_0000_0000 + {57'd0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output-side scoreboard check first, then record an accepted enqueue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_if.valid && mem_if.ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL deq_unexpected: got robid %0h expected no entry", mem_if.robid);
        end else begin
          logic [6:0] exp_id;
          exp_id = sb.pop_front();
          chk("deq_robid", {57'd0, mem_if.robid}, {57'd0, exp_id});
          chk("deq_instr", {32'd0, mem_if.instr}, {32'd0, mk_instr(exp_id)});
          chk("deq_src1", mem_if.src1, mk_src1(exp_id));
          chk("deq_is_load", {63'd0, mem_if.is_load}, {63'd0, exp_id[0]});
        end
      end
      if (enq_if.valid && enq_if.ready && !flush_valid) begin
        sb.push_back(enq_if.robid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [6:0] r);
    enq_if.valid       = v;
    enq_if.robid       = r;
    enq_if.instr       = mk_instr(r);
    enq_if.pc          = {23'd0, r, 2'b00};
    enq_if.src1        = mk_src1(r);
    enq_if.src2        = {57'd0, r} ^ 64'hFFFF;
    enq_if.prd         = r[5:0];
    enq_if.imm         = 64'd16;
    enq_if.is_load     = r[0];
    enq_if.is_store    = ~r[0];
    enq_if.is_unsigned = r[1];
    enq_if.ls_size     = r[1:0];
  endtask

  task automatic push_n(input logic [6:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      drive_enq(1'b1, 7'(start + 7'(k)));
      tick();
    end
    drive_enq(1'b0, 7'h00);
  endtask

  task automatic drain(input int n);
    mem_if.ready = 1'b1;
    repeat (n) tick();
    mem_if.ready = 1'b0;
  endtask

  task automatic do_flush(input logic [6:0] id, input int keep);
    flush_valid = 1'b1;
    flush_robid = id;
    #1;
    chk("flush_mem_valid", {63'd0, mem_if.valid}, 64'd0);
    tick();
    flush_valid = 1'b0;
    while (sb.size() > keep) void'(sb.pop_back());
    chk("flush_occupancy", {60'd0, occupancy}, 64'(keep));
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    flush_valid  = 1'b0;
    flush_robid  = 7'h00;
    mem_if.ready = 1'b0;
    drive_enq(1'b0, 7'h00);
    tick();
    tick();
    chk("rst_occupancy", {60'd0, occupancy}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_if.valid}, 64'd0);
    chk("rst_enq_ready", {63'd0, enq_if.ready}, 64'd1);
    reset_n = 1'b1;

    // Basic in-order fill and drain.
    push_n(7'h01, 3);
    chk("basic_occupancy", {60'd0, occupancy}, 64'd3);
    chk("basic_mem_valid", {63'd0, mem_if.valid}, 64'd1);
    chk("basic_head_robid", {57'd0, mem_if.robid}, 64'h01);
    drain(3);
    chk("basic_drained_occ", {60'd0, occupancy}, 64'd0);
    chk("basic_drained_valid", {63'd0, mem_if.valid}, 64'd0);

    // Full queue refuses enqueue even while popping.
    push_n(7'h10, 8);
    chk("full_occupancy", {60'd0, occupancy}, 64'd8);
    drive_enq(1'b1, 7'h18);
    mem_if.ready = 1'b1;
    chk("full_enq_ready", {63'd0, enq_if.ready}, 64'd0);
    tick();
    chk("full_pop_occ", {60'd0, occupancy}, 64'd7);
    chk("full_pop_enq_ready", {63'd0, enq_if.ready}, 64'd1);
    mem_if.ready = 1'b0;
    tick();
    drive_enq(1'b0, 7'h00);
    chk("full_refill_occ", {60'd0, occupancy}, 64'd8);
    drain(8);
    chk("full_drained_occ", {60'd0, occupancy}, 64'd0);

    // Flush kills younger entries; following enqueue lands after survivors.
    push_n(7'h05, 5);
    chk("flush_pre_occ", {60'd0, occupancy}, 64'd5);
    do_flush(7'h06, 2);
    push_n(7'h07, 1);
    chk("flush_refill_occ", {60'd0, occupancy}, 64'd3);
    chk("flush_head_robid", {57'd0, mem_if.robid}, 64'h05);
    drain(3);
    chk("flush_drained_occ", {60'd0, occupancy}, 64'd0);
    do_flush(7'h00, 0);

    // Wrap-bit age compare.
    push_n(7'h3E, 4);
    chk("wrap_pre_occ", {60'd0, occupancy}, 64'd4);
    do_flush(7'h3F, 2);

    // Flush with enq and pop requested the same cycle: neither happens.
    drive_enq(1'b1, 7'h42);
    mem_if.ready = 1'b1;
    do_flush(7'h3F, 2);
    drive_enq(1'b0, 7'h00);
    mem_if.ready = 1'b0;
    chk("flushcyc_head_robid", {57'd0, mem_if.robid}, 64'h3E);
    drain(2);
    chk("flushcyc_drained_occ", {60'd0, occupancy}, 64'd0);

    // Reset mid-stream discards everything.
    push_n(7'h20, 4);
    chk("midrst_pre_occ", {60'd0, occupancy}, 64'd4);
    reset_n = 1'b0;
    tick();
    chk("midrst_occupancy", {60'd0, occupancy}, 64'd0);
    chk("midrst_mem_valid", {63'd0, mem_if.valid}, 64'd0);
    chk("midrst_enq_ready", {63'd0, enq_if.ready}, 64'd1);
    reset_n = 1'b1;
    sb.delete();
    push_n(7'h24, 1);
    chk("postrst_head_robid", {57'd0, mem_if.robid}, 64'h24);
    drain(1);
    chk("postrst_occ", {60'd0, occupancy}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
